mem_burst_master: RTL and testbench

Initiator-side controller for the CPU's 256×8 data/program memory. It accepts single or burst read/write requests over a valid/ready command interface and drives the memory's `write_enable`/`addr`/`data_in` port. It samples the memory's combinational `data_out`, returning read bytes over a valid/ready response stream. The block sits between the CPU core (or the program loader) and the memory array.

---
 rtl/cpu_mem_pkg.sv | 17 +
 rtl/mem_burst_master.sv | 139 +++++++++++++
 tb/tb_mem_burst_master.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory subsystem: default widths, depth and
// the burst master's state encoding.
package cpu_mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int MEM_DEPTH  = 1 << ADDR_W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_RSP  = 3'd3,
    ST_DONE    = 3'd4
  } mem_ms_state_t;

endpackage

// File: rtl/mem_burst_master.sv
// Burst initiator for the 256x8 CPU memory: valid/ready commands in, memory
// port out, read bytes returned on a valid/ready response stream.
module mem_burst_master
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  mem_ms_state_t     state_r;
  mem_ms_state_t     next_s;
  logic [ADDR_W-1:0] cur_addr_r;
  logic [ADDR_W-1:0] remaining_r;
  logic              wr_burst_r;
  logic              wr_hs_s;
  logic              rsp_hs_s;
  logic              last_s;
  logic [ADDR_W-1:0] addr_inc_s;

  // Handshake decode and next-state selection
  always_comb begin
    next_s     = state_r;
    wr_hs_s    = (state_r == ST_WRITE) && wr_valid;
    rsp_hs_s   = (state_r == ST_RD_RSP) && rsp_ready;
    last_s     = (remaining_r == '0);
    addr_inc_s = cur_addr_r + ADDR_W'(1);
    req_ready  = (state_r == ST_IDLE);
    wr_ready   = (state_r == ST_WRITE);
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          next_s = req_write ? ST_WRITE : ST_RD_ADDR;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (wr_hs_s && last_s) begin
          next_s = ST_DONE;
        end else begin
          next_s = ST_WRITE;
        end
      end
      ST_RD_ADDR: next_s = ST_RD_RSP;
      ST_RD_RSP: begin
        if (rsp_hs_s) begin
          next_s = last_s ? ST_DONE : ST_RD_ADDR;
        end else begin
          next_s = ST_RD_RSP;
        end
      end
      ST_DONE: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // State, counters and all registered outputs; mem_we/done default low each cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cur_addr_r  <= '0;
      remaining_r <= '0;
      wr_burst_r  <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      done        <= 1'b0;
    end else begin
      state_r <= next_s;
      mem_we  <= 1'b0;
      done    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            cur_addr_r  <= req_addr;
            remaining_r <= req_len;
            wr_burst_r  <= req_write;
            if (!req_write) begin
              mem_addr <= req_addr;
            end
          end
        end
        ST_WRITE: begin
          if (wr_hs_s) begin
            mem_we      <= 1'b1;
            mem_addr    <= cur_addr_r;
            mem_wdata   <= wr_data;
            cur_addr_r  <= addr_inc_s;
            remaining_r <= remaining_r - ADDR_W'(1);
          end
        end
        ST_RD_ADDR: begin
          rsp_data  <= mem_rdata;
          rsp_valid <= 1'b1;
        end
        ST_RD_RSP: begin
          if (rsp_hs_s) begin
            rsp_valid <= 1'b0;
            if (last_s) begin
              done <= 1'b1;
            end else begin
              mem_addr    <= addr_inc_s;
              cur_addr_r  <= addr_inc_s;
              remaining_r <= remaining_r - ADDR_W'(1);
            end
          end
        end
        // Reads already pulsed done on the final handshake; writes pulse it here,
        // after the last mem_we cycle has retired.
        ST_DONE: done <= wr_burst_r;
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a behavioural 256x8 memory attached.
module tb_mem_burst_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       done;
  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem [0:255];
  int         total = 0;
  int         bad = 0;
  int         cyc_n = 0;
  int         done_cnt = 0;
  logic [7:0] ev_addr[$];
  logic [7:0] ev_data[$];
  int         ev_cyc[$];
  logic [7:0] rq[$];
  logic [7:0] st_data[$];
  logic [7:0] st_addr[$];
  logic [7:0] wq[$];

  always #5 clk = ~clk;

  mem_burst_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .done(done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // memory model: synchronous write, combinational read
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
    cyc_n <= cyc_n + 1;
  end

  // monitor on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      ev_addr.push_back(mem_addr);
      ev_data.push_back(mem_wdata);
      ev_cyc.push_back(cyc_n);
    end
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) rq.push_back(rsp_data);
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic run_write(input logic [7:0] addr, input logic [7:0] len,
                           input int gap_beat, input int gap_n);
    int beat = 0;
    int gaps = 0;
    int g = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_len = len;
    while (req_ready !== 1'b1 && g < 20) begin cyc(); g++; end
    cyc();
    req_valid = 1'b0;
    g = 0;
    while (beat <= int'(len) && g < 300) begin
      if (beat == gap_beat && gaps < gap_n) begin
        wr_valid = 1'b0;
        gaps++;
      end else begin
        wr_valid = 1'b1;
        wr_data  = wq[beat];
        if (wr_ready === 1'b1) beat++;
      end
      cyc();
      g++;
    end
    wr_valid = 1'b0;
  endtask

  task automatic run_read(input logic [7:0] addr, input logic [7:0] len,
                          input int stall_beat, input int stall_n);
    int beat = 0;
    int stalls = 0;
    int g = 0;
    st_data.delete(); st_addr.delete();
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = len;
    cyc();
    req_valid = 1'b0;
    while (beat <= int'(len) && g < 300) begin
      if (rsp_valid === 1'b1 && beat == stall_beat && stalls < stall_n) begin
        rsp_ready = 1'b0;
        stalls++;
        st_data.push_back(rsp_data);
        st_addr.push_back(mem_addr);
      end else begin
        rsp_ready = 1'b1;
        if (rsp_valid === 1'b1) beat++;
      end
      cyc();
      g++;
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_len = 8'h00;
    wr_valid = 1'b0; wr_data = 8'h00; rsp_ready = 1'b0;
    cyc(); cyc();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
    total++; if (mem_wdata !== 8'h00) begin bad++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    ev_addr.delete(); ev_data.delete(); ev_cyc.delete();
    wq = '{8'hA5};
    run_write(8'h10, 8'h00, -1, 0);
    total++; if (mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 8'hA5) begin bad++;
      $display("FAIL single_wr_beat: got we=%b addr=%h data=%h want 1/10/a5", mem_we, mem_addr, mem_wdata); end
    cyc();
    total++; if (done !== 1'b1 || mem_we !== 1'b0) begin bad++;
      $display("FAIL single_wr_done: got done=%b we=%b want 1/0", done, mem_we); end
    cyc();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL single_wr_done_pulse: got %b want 0", done); end
    total++; if (ev_addr.size() != 1) begin bad++; $display("FAIL single_wr_count: got %0d want 1", ev_addr.size()); end
    rq.delete();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10; req_len = 8'h00;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL single_rd_req_ready: got %b want 1", req_ready); end
    cyc();
    req_valid = 1'b0; rsp_ready = 1'b1;
    total++; if (rsp_valid !== 1'b0 || mem_addr !== 8'h10) begin bad++;
      $display("FAIL single_rd_addr: got valid=%b addr=%h want 0/10", rsp_valid, mem_addr); end
    cyc();
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5) begin bad++;
      $display("FAIL single_rd_rsp: got valid=%b data=%h want 1/a5", rsp_valid, rsp_data); end
    cyc();
    total++; if (rsp_valid !== 1'b0 || done !== 1'b1) begin bad++;
      $display("FAIL single_rd_done: got valid=%b done=%b want 0/1", rsp_valid, done); end
    rsp_ready = 1'b0;
    cyc();
    total++; if (done !== 1'b0 || req_ready !== 1'b1) begin bad++;
      $display("FAIL single_rd_idle: got done=%b req_ready=%b want 0/1", done, req_ready); end
  endtask

  task automatic test_wrap();
    logic [7:0] ea [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    int d0 = done_cnt;
    ev_addr.delete(); ev_data.delete(); ev_cyc.delete();
    wq = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_write(8'hFE, 8'h03, -1, 0);
    repeat (3) cyc();
    total++; if (ev_addr.size() != 4) begin bad++; $display("FAIL wrap_wr_count: got %0d want 4", ev_addr.size()); end
    for (int i = 0; i < 4 && i < ev_addr.size(); i++) begin
      total++; if (ev_addr[i] !== ea[i] || ev_data[i] !== 8'(i + 1)) begin bad++;
        $display("FAIL wrap_wr_beat%0d: got %h/%h want %h/%h", i, ev_addr[i], ev_data[i], ea[i], 8'(i + 1)); end
    end
    total++; if (done_cnt != d0 + 1) begin bad++; $display("FAIL wrap_wr_done: got %0d want %0d", done_cnt, d0 + 1); end
    rq.delete();
    run_read(8'hFE, 8'h03, -1, 0);
    repeat (3) cyc();
    total++; if (rq.size() != 4) begin bad++; $display("FAIL wrap_rd_count: got %0d want 4", rq.size()); end
    for (int i = 0; i < 4 && i < rq.size(); i++) begin
      total++; if (rq[i] !== 8'(i + 1)) begin bad++; $display("FAIL wrap_rd_beat%0d: got %h want %h", i, rq[i], 8'(i + 1)); end
    end
    total++; if (ev_addr.size() != 4) begin bad++; $display("FAIL wrap_rd_no_we: got %0d writes want 4", ev_addr.size()); end
    total++; if (done_cnt != d0 + 2) begin bad++; $display("FAIL wrap_rd_done: got %0d want %0d", done_cnt, d0 + 2); end
  endtask

  task automatic test_write_gaps();
    logic [7:0] ed [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    int ec [3] = '{3, 1, 1};
    ev_addr.delete(); ev_data.delete(); ev_cyc.delete();
    wq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_write(8'h20, 8'h03, 1, 2);
    repeat (3) cyc();
    total++; if (ev_addr.size() != 4) begin bad++; $display("FAIL gap_count: got %0d want 4", ev_addr.size()); end
    for (int i = 0; i < 4 && i < ev_addr.size(); i++) begin
      total++; if (ev_addr[i] !== 8'(8'h20 + i) || ev_data[i] !== ed[i]) begin bad++;
        $display("FAIL gap_beat%0d: got %h/%h want %h/%h", i, ev_addr[i], ev_data[i], 8'(8'h20 + i), ed[i]); end
    end
    for (int i = 0; i < 3 && i + 1 < ev_cyc.size(); i++) begin
      total++; if (ev_cyc[i + 1] - ev_cyc[i] != ec[i]) begin bad++;
        $display("FAIL gap_spacing%0d: got %0d want %0d", i, ev_cyc[i + 1] - ev_cyc[i], ec[i]); end
    end
  endtask

  task automatic test_read_backpressure();
    logic [7:0] ed [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    wq = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_write(8'h40, 8'h03, -1, 0);
    repeat (3) cyc();
    rq.delete();
    run_read(8'h40, 8'h03, 1, 3);
    repeat (3) cyc();
    total++; if (rq.size() != 4) begin bad++; $display("FAIL bp_count: got %0d want 4", rq.size()); end
    for (int i = 0; i < 4 && i < rq.size(); i++) begin
      total++; if (rq[i] !== ed[i]) begin bad++; $display("FAIL bp_beat%0d: got %h want %h", i, rq[i], ed[i]); end
    end
    total++; if (st_data.size() != 3) begin bad++; $display("FAIL bp_stalls: got %0d want 3", st_data.size()); end
    for (int i = 0; i < st_data.size(); i++) begin
      total++; if (st_data[i] !== 8'h22 || st_addr[i] !== 8'h41) begin bad++;
        $display("FAIL bp_hold%0d: got %h@%h want 22@41", i, st_data[i], st_addr[i]); end
    end
  endtask

  task automatic test_reset_mid_write();
    int d0 = done_cnt;
    ev_addr.delete(); ev_data.delete(); ev_cyc.delete();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h80; req_len = 8'h04;
    cyc();
    req_valid = 1'b0;
    wr_valid = 1'b1; wr_data = 8'h71;
    cyc();
    wr_data = 8'h72;
    cyc();
    wr_data = 8'h73; rst = 1'b1;
    cyc();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rstmid_mem_we: got %b want 0", mem_we); end
    total++; if (req_ready !== 1'b1 || wr_ready !== 1'b0) begin bad++;
      $display("FAIL rstmid_idle: got req_ready=%b wr_ready=%b want 1/0", req_ready, wr_ready); end
    rst = 1'b0; wr_valid = 1'b0;
    repeat (4) cyc();
    total++; if (done_cnt != d0) begin bad++; $display("FAIL rstmid_no_done: got %0d want %0d", done_cnt, d0); end
    total++; if (ev_addr.size() != 2) begin bad++; $display("FAIL rstmid_beats: got %0d want 2", ev_addr.size()); end
    wq = '{8'h5A};
    run_write(8'h90, 8'h00, -1, 0);
    repeat (3) cyc();
    total++; if (ev_addr.size() != 3 || ev_addr[ev_addr.size() - 1] !== 8'h90 || ev_data[ev_data.size() - 1] !== 8'h5A) begin bad++;
      $display("FAIL rstmid_next_wr: got n=%0d last=%h/%h want 3 90/5a", ev_addr.size(),
               ev_addr[ev_addr.size() - 1], ev_data[ev_data.size() - 1]); end
    rq.delete();
    run_read(8'h90, 8'h00, -1, 0);
    repeat (2) cyc();
    total++; if (rq.size() != 1 || rq[0] !== 8'h5A) begin bad++;
      $display("FAIL rstmid_next_rd: got n=%0d data=%h want 1 5a", rq.size(), rq[0]); end
    total++; if (done_cnt != d0 + 2) begin bad++; $display("FAIL rstmid_next_done: got %0d want %0d", done_cnt, d0 + 2); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_write_gaps();
    test_read_backpressure();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
